// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and run-control unit for the 5-stage RV32I pipeline.
// It drives stall/flush controls, selects E-stage forwarding, sequences HALT/RUN/STEP
// and keeps saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             cnt_clr,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             loadE,
  input  logic             pcsrcE,
  input  logic             dmem_reqM,
  input  logic             dmem_ackM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             pipe_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    StHalt = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, stall_q, flush_q;
  logic             memwait, lwstall, lw_applied, stall_inc, flush_inc;

  assign pipe_en = (state_q != StHalt);
  assign state   = state_q;
  assign cyc_cnt   = cyc_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  assign memwait = dmem_reqM & ~dmem_ackM;
  assign lwstall = loadE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));
  // A load-use stall only takes effect when neither memwait nor a taken branch outranks it.
  assign lw_applied = lwstall & ~memwait & ~pcsrcE;
  assign stall_inc  = pipe_en & (memwait | lw_applied);
  assign flush_inc  = pipe_en & pcsrcE & ~memwait;

  // Prioritised stall/flush controls; HALT freezes every pipeline register.
  always_comb begin
    stallF = 1'b1;
    stallD = 1'b1;
    stallE = 1'b1;
    stallM = 1'b1;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (pipe_en) begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      if (memwait) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (pcsrcE) begin
        // D holds a wrong-path instruction, so any load-use match is moot.
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (lwstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  // E-stage operand forwarding: M result beats W result, x0 never forwarded.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (regwriteM && (rdM != 5'd0) && (rdM == rs1E))      forwardAE = 2'b10;
    else if (regwriteW && (rdW != 5'd0) && (rdW == rs1E)) forwardAE = 2'b01;
    if (regwriteM && (rdM != 5'd0) && (rdM == rs2E))      forwardBE = 2'b10;
    else if (regwriteW && (rdW != 5'd0) && (rdW == rs2E)) forwardBE = 2'b01;
  end

  // Run-control next state; halt_req outranks run_req, which outranks step_req.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHalt: begin
        if (halt_req)      state_d = StHalt;
        else if (run_req)  state_d = StRun;
        else if (step_req) state_d = StStep;
      end
      StRun:  if (halt_req) state_d = StHalt;
      // A step ends after its first productive cycle, i.e. once memwait is gone.
      StStep: if (halt_req || !memwait) state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  // Run-control state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StHalt;
    else       state_q <= state_d;
  end

  // Saturating performance counters; clear beats increment.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pipe_en && (cyc_q != '1))     cyc_q   <= cyc_q + CNT_W'(1);
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a randomized run
// checked against a behavioural model. A second instance with 4-bit counters covers saturation.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset, run_req, halt_req, step_req, cnt_clr;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic regwriteM, regwriteW, loadE, pcsrcE, dmem_reqM, dmem_ackM;

  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, pipe_en;
  logic [1:0] forwardAE, forwardBE, state;
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;

  logic s4F, s4D, s4E, s4M, f4D, f4E, f4W, pe4;
  logic [1:0] fa4, fb4, st4;
  logic [3:0] c4_cyc, c4_stall, c4_flush;

  logic [6:0] haz;
  assign haz = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};

  int checks = 0;
  int failures = 0;

  // Reference model state: 0 HALT, 1 RUN, 2 STEP; unbounded counts.
  int    m_state = 0;
  longint m_cyc = 0, m_stall = 0, m_flush = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .cnt_clr(cnt_clr), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW), .loadE(loadE),
    .pcsrcE(pcsrcE), .dmem_reqM(dmem_reqM), .dmem_ackM(dmem_ackM), .stallF(stallF),
    .stallD(stallD), .stallE(stallE), .stallM(stallM), .flushD(flushD), .flushE(flushE),
    .flushW(flushW), .forwardAE(forwardAE), .forwardBE(forwardBE), .pipe_en(pipe_en),
    .state(state), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .cnt_clr(cnt_clr), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW), .loadE(loadE),
    .pcsrcE(pcsrcE), .dmem_reqM(dmem_reqM), .dmem_ackM(dmem_ackM), .stallF(s4F),
    .stallD(s4D), .stallE(s4E), .stallM(s4M), .flushD(f4D), .flushE(f4E),
    .flushW(f4W), .forwardAE(fa4), .forwardBE(fb4), .pipe_en(pe4),
    .state(st4), .cyc_cnt(c4_cyc), .stall_cnt(c4_stall), .flush_cnt(c4_flush)
  );

  function automatic bit load_use();
    return loadE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
  endfunction

  // Expected {stallF,stallD,stallE,stallM,flushD,flushE,flushW} from the priority rules.
  function automatic logic [6:0] exp_haz();
    if (m_state == 0)               return 7'b1111_000;
    if (dmem_reqM && !dmem_ackM)    return 7'b1111_001;
    if (pcsrcE)                     return 7'b0000_110;
    if (load_use())                 return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic longint sat4(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  // Advance the model by one clock using the inputs held across the edge.
  function automatic void model_update();
    bit mw = dmem_reqM && !dmem_ackM;
    if (reset) begin
      m_state = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (cnt_clr) begin
      m_cyc = 0; m_stall = 0; m_flush = 0;
    end else if (m_state != 0) begin
      m_cyc++;
      if (mw || (load_use() && !pcsrcE)) m_stall++;
      if (pcsrcE && !mw) m_flush++;
    end
    case (m_state)
      0: if (halt_req) m_state = 0; else if (run_req) m_state = 1; else if (step_req) m_state = 2;
      1: if (halt_req) m_state = 0;
      default: if (halt_req || !mw) m_state = 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    {run_req, halt_req, step_req, cnt_clr} = '0;
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {regwriteM, regwriteW, loadE, pcsrcE, dmem_reqM, dmem_ackM} = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (state !== 2'b00) begin failures++;
      $display("FAIL reset_state got=%b want=00", state); end
    checks++; if (haz !== 7'b1111_000) begin failures++;
      $display("FAIL reset_haz got=%b want=1111000", haz); end
    checks++; if (pipe_en !== 1'b0) begin failures++;
      $display("FAIL reset_pipe_en got=%b want=0", pipe_en); end
    checks++; if ({cyc_cnt, stall_cnt, flush_cnt} !== 96'd0) begin failures++;
      $display("FAIL reset_cnt got=%0d/%0d/%0d want=0/0/0", cyc_cnt, stall_cnt, flush_cnt); end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    checks++; if (state !== 2'b01) begin failures++;
      $display("FAIL run_entry got=%b want=01", state); end
  endtask

  task automatic test_load_use();
    longint ms = m_stall, mf = m_flush;
    loadE = 1'b1; rdE = 5'd5; rs2D = 5'd5; rs1D = 5'd9;
    #1;
    checks++; if (haz !== 7'b1100_010) begin failures++;
      $display("FAIL lwstall_haz got=%b want=1100010", haz); end
    tick();
    checks++; if (stall_cnt !== 32'(ms + 1)) begin failures++;
      $display("FAIL lwstall_cnt got=%0d want=%0d", stall_cnt, ms + 1); end
    pcsrcE = 1'b1;
    #1;
    checks++; if (haz !== 7'b0000_110) begin failures++;
      $display("FAIL branch_over_lw got=%b want=0000110", haz); end
    tick();
    checks++; if (stall_cnt !== 32'(ms + 1) || flush_cnt !== 32'(mf + 1)) begin failures++;
      $display("FAIL branch_cnt got=%0d/%0d want=%0d/%0d", stall_cnt, flush_cnt, ms + 1, mf + 1);
    end
    // Load into x0 never stalls.
    pcsrcE = 1'b0; rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
    #1;
    checks++; if (haz !== 7'b0000_000) begin failures++;
      $display("FAIL lw_x0 got=%b want=0000000", haz); end
    clear_inputs();
  endtask

  task automatic test_memwait();
    longint ms = m_stall;
    dmem_reqM = 1'b1; dmem_ackM = 1'b0;
    loadE = 1'b1; rdE = 5'd3; rs1D = 5'd3; pcsrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (haz !== 7'b1111_001) begin failures++;
        $display("FAIL memwait_haz cyc=%0d got=%b want=1111001", i, haz); end
      tick();
    end
    dmem_ackM = 1'b1; loadE = 1'b0; pcsrcE = 1'b0;
    #1;
    checks++; if (haz !== 7'b0000_000) begin failures++;
      $display("FAIL memwait_release got=%b want=0000000", haz); end
    checks++; if (stall_cnt !== 32'(ms + 3)) begin failures++;
      $display("FAIL memwait_cnt got=%0d want=%0d", stall_cnt, ms + 3); end
    tick();
    clear_inputs();
  endtask

  task automatic test_forwarding();
    rs1E = 5'd7; rs2E = 5'd7; rdM = 5'd7; rdW = 5'd7; regwriteM = 1'b1; regwriteW = 1'b1;
    #1;
    checks++; if (forwardAE !== 2'b10 || forwardBE !== 2'b10) begin failures++;
      $display("FAIL fwd_m got=%b/%b want=10/10", forwardAE, forwardBE); end
    regwriteM = 1'b0;
    #1;
    checks++; if (forwardAE !== 2'b01 || forwardBE !== 2'b01) begin failures++;
      $display("FAIL fwd_w got=%b/%b want=01/01", forwardAE, forwardBE); end
    regwriteM = 1'b1; rdM = 5'd0; rdW = 5'd0;
    #1;
    checks++; if (forwardAE !== 2'b00 || forwardBE !== 2'b00) begin failures++;
      $display("FAIL fwd_none got=%b/%b want=00/00", forwardAE, forwardBE); end
    rs1E = 5'd0; rs2E = 5'd4; rdW = 5'd4;
    #1;
    checks++; if (forwardAE !== 2'b00 || forwardBE !== 2'b01) begin failures++;
      $display("FAIL fwd_x0 got=%b/%b want=00/01", forwardAE, forwardBE); end
    clear_inputs();
  endtask

  task automatic test_step();
    longint mc;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    mc = m_cyc;
    dmem_reqM = 1'b1; dmem_ackM = 1'b0; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    checks++; if (state !== 2'b10) begin failures++;
      $display("FAIL step_entry got=%b want=10", state); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (state !== 2'b10) begin failures++;
        $display("FAIL step_hold cyc=%0d got=%b want=10", i, state); end
    end
    dmem_ackM = 1'b1;
    tick();
    checks++; if (state !== 2'b00) begin failures++;
      $display("FAIL step_done got=%b want=00", state); end
    clear_inputs();
    tick();
    checks++; if (cyc_cnt !== 32'(mc + 3)) begin failures++;
      $display("FAIL step_cyc got=%0d want=%0d", cyc_cnt, mc + 3); end
  endtask

  task automatic test_saturation();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; run_req = 1'b1;
    tick();
    run_req = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (c4_cyc !== 4'hF || cyc_cnt !== 32'd20) begin failures++;
      $display("FAIL cyc_sat got=%0d/%0d want=15/20", c4_cyc, cyc_cnt); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (c4_cyc !== 4'd0 || cyc_cnt !== 32'd0) begin failures++;
      $display("FAIL clr_over_inc got=%0d/%0d want=0/0", c4_cyc, cyc_cnt); end
    halt_req = 1'b1; run_req = 1'b1;
    tick();
    checks++; if (state !== 2'b00) begin failures++;
      $display("FAIL halt_beats_run_from_run got=%b want=00", state); end
    tick();
    halt_req = 1'b0; run_req = 1'b0;
    checks++; if (state !== 2'b00) begin failures++;
      $display("FAIL halt_beats_run_from_halt got=%b want=00", state); end
    dmem_reqM = 1'b1; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    checks++; if (state !== 2'b10) begin failures++;
      $display("FAIL step_before_reset got=%b want=10", state); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (state !== 2'b00 || cyc_cnt !== 32'd0) begin failures++;
      $display("FAIL reset_mid_step got=%b/%0d want=00/0", state, cyc_cnt); end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
      rdE = 5'($urandom_range(0, 3)); rdM = 5'($urandom_range(0, 3));
      rdW = 5'($urandom_range(0, 3));
      regwriteM = ($urandom_range(0, 1) == 1); regwriteW = ($urandom_range(0, 1) == 1);
      loadE = ($urandom_range(0, 1) == 1); pcsrcE = ($urandom_range(0, 3) == 0);
      dmem_reqM = ($urandom_range(0, 2) == 0); dmem_ackM = ($urandom_range(0, 1) == 1);
      run_req = ($urandom_range(0, 7) == 0); halt_req = ($urandom_range(0, 9) == 0);
      step_req = ($urandom_range(0, 5) == 0); cnt_clr = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 59) == 0);
      #1;
      checks++; if (haz !== exp_haz() || pipe_en !== (m_state != 0)) begin failures++;
        $display("FAIL rand_haz n=%0d got=%b/%b want=%b/%b", n, haz, pipe_en, exp_haz(),
                 m_state != 0); end
      checks++; if (forwardAE !== exp_fwd(rs1E) || forwardBE !== exp_fwd(rs2E)) begin
        failures++;
        $display("FAIL rand_fwd n=%0d got=%b/%b want=%b/%b", n, forwardAE, forwardBE,
                 exp_fwd(rs1E), exp_fwd(rs2E)); end
      tick();
      checks++; if (state !== 2'(m_state)) begin failures++;
        $display("FAIL rand_state n=%0d got=%b want=%0d", n, state, m_state); end
      checks++; if (cyc_cnt !== 32'(m_cyc) || stall_cnt !== 32'(m_stall) ||
                    flush_cnt !== 32'(m_flush)) begin failures++;
        $display("FAIL rand_cnt n=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", n, cyc_cnt, stall_cnt,
                 flush_cnt, m_cyc, m_stall, m_flush); end
      checks++; if (c4_cyc !== 4'(sat4(m_cyc)) || c4_stall !== 4'(sat4(m_stall)) ||
                    c4_flush !== 4'(sat4(m_flush))) begin failures++;
        $display("FAIL rand_cnt4 n=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", n, c4_cyc, c4_stall,
                 c4_flush, sat4(m_cyc), sat4(m_stall), sat4(m_flush)); end
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_memwait();
    test_forwarding();
    test_step();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
